// File: rtl/dot_product_feeder.sv
// Sequences operand beats into an external per-lane MAC array, then reduces the lanes to one sum.
// Optional DOTPROD_BEAT_COUNT_EN adds a saturating beat_count output for the last completed vector.
module dot_product_feeder #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Para_Deg   = 3,
  localparam int unsigned Sum_Width = 2 * Data_Width + $clog2(Para_Deg)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [Para_Deg*Data_Width-1:0]      in_data0,
  input  logic [Para_Deg*Data_Width-1:0]      in_data1,
  input  logic                                in_last,
  output logic                                pe_load_old_output,
  output logic [Para_Deg*Data_Width-1:0]      pe_data0,
  output logic [Para_Deg*Data_Width-1:0]      pe_data1,
  output logic [Para_Deg*2*Data_Width-1:0]    pe_old_output,
  input  logic [Para_Deg*2*Data_Width-1:0]    pe_result,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [Sum_Width-1:0]                out_sum
`ifdef DOTPROD_BEAT_COUNT_EN
  ,
  output logic [15:0]                         beat_count
`endif
);

  localparam int unsigned ProdWidth = 2 * Data_Width;

  typedef enum logic [2:0] {StIdle, StFeed, StDrain, StReduce, StOut} state_e;

  state_e               state_q;
  logic                 accept;
  logic [Sum_Width-1:0] lane_sum;

  assign in_ready      = (state_q == StIdle) || (state_q == StFeed);
  assign accept        = in_valid && in_ready;
  assign pe_old_output = pe_result;

  // Exact reduction: each lane is zero-extended before adding so the sum never wraps.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < int'(Para_Deg); i++) begin
      lane_sum = lane_sum + Sum_Width'(pe_result[i*ProdWidth +: ProdWidth]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= StIdle;
      pe_data0           <= '0;
      pe_data1           <= '0;
      pe_load_old_output <= 1'b0;
      out_valid          <= 1'b0;
      out_sum            <= '0;
    end else begin
      pe_data0 <= '0;
      pe_data1 <= '0;
      unique case (state_q)
        StIdle: begin
          pe_load_old_output <= 1'b0;
          if (accept) begin
            pe_data0 <= in_data0;
            pe_data1 <= in_data1;
            state_q  <= in_last ? StDrain : StFeed;
          end
        end
        StFeed: begin
          // Idle cycles feed zeros with feedback on, so lane accumulators hold.
          pe_load_old_output <= 1'b1;
          if (accept) begin
            pe_data0 <= in_data0;
            pe_data1 <= in_data1;
            if (in_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          pe_load_old_output <= 1'b1;
          state_q            <= StReduce;
        end
        StReduce: begin
          pe_load_old_output <= 1'b1;
          out_sum            <= lane_sum;
          out_valid          <= 1'b1;
          state_q            <= StOut;
        end
        StOut: begin
          pe_load_old_output <= 1'b0;
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DOTPROD_BEAT_COUNT_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      if (state_q == StIdle)           beat_cnt_d = 16'd1;
      else if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt_q <= '0;
      beat_count <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      if (accept && in_last) beat_count <= beat_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_dot_product_feeder.sv
// Randomized bench for dot_product_feeder with a behavioural PE array and a dot-product reference.
module tb_dot_product_feeder;

  localparam int DW = 8;
  localparam int PD = 3;
  localparam int SW = 2 * DW + $clog2(PD);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PD*DW-1:0]  in_data0 = '0;
  logic [PD*DW-1:0]  in_data1 = '0;
  logic              in_last = 1'b0;
  logic              pe_load_old_output;
  logic [PD*DW-1:0]  pe_data0, pe_data1;
  logic [PD*2*DW-1:0] pe_old_output;
  logic [PD*2*DW-1:0] pe_result = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [SW-1:0]     out_sum;
`ifdef DOTPROD_BEAT_COUNT_EN
  logic [15:0]       beat_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [PD*DW-1:0] b0 [8];
  logic [PD*DW-1:0] b1 [8];

  dot_product_feeder #(.Data_Width(DW), .Para_Deg(PD)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data0           (in_data0),
    .in_data1           (in_data1),
    .in_last            (in_last),
    .pe_load_old_output (pe_load_old_output),
    .pe_data0           (pe_data0),
    .pe_data1           (pe_data1),
    .pe_old_output      (pe_old_output),
    .pe_result          (pe_result),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_sum            (out_sum)
`ifdef DOTPROD_BEAT_COUNT_EN
    ,
    .beat_count         (beat_count)
`endif
  );

  always #5 clk = ~clk;

  // PE array: per-lane multiply-accumulate, wrapping at 2*DW bits.
  always @(posedge clk) begin
    for (int i = 0; i < PD; i++) begin
      pe_result[i*2*DW +: 2*DW] <= pe_data0[i*DW +: DW] * pe_data1[i*DW +: DW]
                                   + (pe_load_old_output ? pe_old_output[i*2*DW +: 2*DW] : 16'd0);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: each lane sums its products modulo 2^(2*DW); lanes are then added exactly.
  function automatic longint ref_sum(input int n);
    longint total = 0;
    for (int l = 0; l < PD; l++) begin
      longint acc = 0;
      for (int k = 0; k < n; k++) begin
        acc = (acc + longint'(b0[k][l*DW +: DW]) * longint'(b1[k][l*DW +: DW])) % 65536;
      end
      total += acc;
    end
    return total;
  endfunction

  task automatic drive_beat(input int b, input logic last);
    check_eq("in_ready_beat", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data0 = b0[b];
    in_data1 = b1[b];
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq("pe_data0", 64'(pe_data0), 64'(b0[b]));
    check_eq("pe_data1", 64'(pe_data1), 64'(b1[b]));
    check_eq("pe_load", 64'(pe_load_old_output), 64'(b != 0));
  endtask

  task automatic run_vector(input int n, input int gap, input int hold);
    longint exp_sum;
    exp_sum = ref_sum(n);
    for (int b = 0; b < n; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          check_eq("gap_load", 64'(pe_load_old_output), 64'd1);
          check_eq("gap_data0", 64'(pe_data0), 64'd0);
        end
      end
      drive_beat(b, b == n - 1);
    end
    check_eq("ov_accept_edge", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("drain_ready", 64'(in_ready), 64'd0);
    check_eq("ov_drain", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("out_valid", 64'(out_valid), 64'd1);
    check_eq("out_sum", 64'(out_sum), 64'(exp_sum));
`ifdef DOTPROD_BEAT_COUNT_EN
    check_eq("beat_count", 64'(beat_count), 64'(n));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_sum", 64'(out_sum), 64'(exp_sum));
      check_eq("hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("ov_cleared", 64'(out_valid), 64'd0);
    check_eq("ready_again", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #12;
    check_eq("rst_ov", 64'(out_valid), 64'd0);
    check_eq("rst_sum", 64'(out_sum), 64'd0);
    check_eq("rst_load", 64'(pe_load_old_output), 64'd0);
    check_eq("rst_data0", 64'(pe_data0), 64'd0);
    check_eq("rst_data1", 64'(pe_data1), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst_ready", 64'(in_ready), 64'd1);

    // {1,2,3} x {4,5,6}, single beat -> 32
    b0[0] = 24'h030201; b1[0] = 24'h060504;
    run_vector(1, 0, 0);
    check_eq("ref_32", 64'(ref_sum(1)), 64'd32);

    // {1,1,1}x{2,2,2} then {3,3,3}x{3,3,3} -> 33, back-to-back and with a 3-cycle gap
    b0[0] = 24'h010101; b1[0] = 24'h020202;
    b0[1] = 24'h030303; b1[1] = 24'h030303;
    run_vector(2, 0, 0);
    run_vector(2, 3, 0);

    // 255x255 on all lanes: two beats wrap per lane, one beat does not
    b0[0] = 24'hFFFFFF; b1[0] = 24'hFFFFFF;
    b0[1] = 24'hFFFFFF; b1[1] = 24'hFFFFFF;
    run_vector(2, 0, 0);
    run_vector(1, 0, 0);

    // Backpressure for 5 cycles in OUT
    b0[0] = 24'h030201; b1[0] = 24'h060504;
    run_vector(1, 0, 5);

    // Reset after 2 of 3 beats discards the partial vector
    b0[0] = 24'h112233; b1[0] = 24'h445566;
    b0[1] = 24'h778899; b1[1] = 24'hAABBCC;
    drive_beat(0, 1'b0);
    drive_beat(1, 1'b0);
    reset = 1'b1;
    #2;
    check_eq("mid_rst_load", 64'(pe_load_old_output), 64'd0);
    check_eq("mid_rst_data0", 64'(pe_data0), 64'd0);
    check_eq("mid_rst_ov", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("mid_rst_ready", 64'(in_ready), 64'd1);
    b0[0] = 24'h030201; b1[0] = 24'h010101;
    run_vector(1, 0, 0);

    // Randomized vectors
    for (int t = 0; t < 30; t++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          b0[k] = 24'hFFFFFF; b1[k] = 24'hFFFFFF;
        end else begin
          b0[k] = 24'($urandom); b1[k] = 24'($urandom);
        end
      end
      run_vector(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
